sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 10, data word width, used for documentation consistency only and with no effect on ports.
REQ-002 The block SHALL have parameter OP_W, default 3, opcode width.
REQ-003 The block SHALL have port clock  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port n_reset  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port op  input  OP_W  opcode field of the instruction register.
REQ-006 The block SHALL have port z_flag  input  1  accumulator-zero flag from the ALU.
REQ-007 The block SHALL have port ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor  output  1 each  ALU controls.
REQ-008 The block SHALL have port PC_bus, load_PC, INC_PC  output  1 each  program counter controls.
REQ-009 The block SHALL have port MDR_bus, load_MDR, load_MAR, load_IR, Addr_bus  output  1 each  register and bus controls.
REQ-010 The block SHALL have port CS, R_NW  output  1 each  memory chip-select and read-not-write.
REQ-011 The block SHALL have port halted  output  1  processor halted; this port exists only when HALT_EN is defined.

Function
REQ-012 The state register SHALL hold one of FETCH0, FETCH1, FETCH2, DECODE, ST0, ST1, RD0, RD1, HALT; it updates on the clock rising edge, and outputs SHALL be a combinational decode of state, op and z_flag.
REQ-013 FETCH0 SHALL assert PC_bus, load_MAR, load_PC and INC_PC, then go to FETCH1.
REQ-014 FETCH1 SHALL assert CS, R_NW and load_MDR, then go to FETCH2.
REQ-015 FETCH2 SHALL assert MDR_bus and load_IR, then go to DECODE.
REQ-016 DECODE SHALL assert Addr_bus, plus either load_MAR (non-branch op) or load_PC (BNE with z_flag=0).
REQ-017 From DECODE, op 001 (STORE) SHALL go to ST0; op 000, 010, 011, 101 or 110 SHALL go to RD0; op 100 (BNE) SHALL go to FETCH0.
REQ-018 ST0 SHALL assert ACC_bus and load_MDR, then go to ST1; ST1 SHALL assert CS with R_NW=0, then go to FETCH0.
REQ-019 RD0 SHALL assert CS, R_NW and load_MDR, then go to RD1.
REQ-020 RD1 SHALL assert MDR_bus and load_ACC, then go to FETCH0.
REQ-021 In RD1, op 000 (LOAD) SHALL leave ALU_ACC=0.
REQ-022 In RD1, ops 010, 011, 101 and 110 SHALL assert ALU_ACC plus exactly one of ALU_add, ALU_sub, ALU_xor or ALU_xnor, respectively.
REQ-023 Instruction latency SHALL be 6 cycles for LOAD, STORE and ALU ops, and 4 cycles for BNE whether taken or not.
REQ-024 In every state, at most one of ACC_bus, PC_bus, MDR_bus and Addr_bus SHALL be 1.
REQ-025 Within one cycle, at most one of ALU_add, ALU_sub, ALU_xor and ALU_xnor SHALL be 1, and any of them SHALL be 1 only while ALU_ACC=1.
REQ-026 In BNE, z_flag SHALL be sampled combinationally in DECODE only; a z_flag change in any other state SHALL have no effect.
REQ-027 Any output not listed for a state SHALL be 0 in that state.
REQ-028 Unreachable state encodings SHALL transition to FETCH0 with all outputs at 0.

Reset
REQ-029 While n_reset=0 at a rising edge, the next state SHALL be FETCH0.
REQ-030 While n_reset=0, all outputs, including halted, SHALL be forced to 0 combinationally.
REQ-031 Reset asserted in any state, including mid-STORE or HALT, SHALL abandon the instruction without a memory write after the reset edge.
REQ-032 After n_reset deasserts, the first cycle SHALL be FETCH0.

Configuration
REQ-033 With macro SEQUENCER_HALT_EN defined, op 111 in DECODE SHALL go to HALT.
REQ-034 HALT SHALL hold all control outputs at 0 with halted=1 until reset.
REQ-035 Without SEQUENCER_HALT_EN, op 111 SHALL be a NOP (DECODE goes to FETCH0, 4 cycles) and the halted port and HALT state SHALL be absent.

Verification
REQ-036 A bench SHALL cover: reset, then op=000 held -> FETCH0 asserts PC_bus, load_MAR, INC_PC and load_PC; RD1 in cycle 6 asserts MDR_bus and load_ACC with ALU_ACC=0; FETCH0 again in cycle 7.
REQ-037 A bench SHALL cover: op=010/011/101/110 -> RD1 asserts ALU_ACC with only ALU_add/ALU_sub/ALU_xor/ALU_xnor, respectively.
REQ-038 A bench SHALL cover: op=001 -> ST0 asserts ACC_bus and load_MDR; ST1 asserts CS=1 and R_NW=0; the cycle count is 6.
REQ-039 A bench SHALL cover: op=100 with z_flag=0 -> DECODE asserts Addr_bus and load_PC and not load_MAR; with z_flag=1 -> Addr_bus and load_MAR with load_PC=0; both take 4 cycles.
REQ-040 A bench SHALL cover: n_reset=0 during ST0 -> all outputs 0 immediately, no CS in the following cycle, and FETCH0 after release.
REQ-041 A bench SHALL cover: op=111 with SEQUENCER_HALT_EN -> halted=1 from cycle 4 onward with all controls 0 for at least 20 cycles; without the macro -> FETCH0 at cycle 5.

Source files
------------

// File: rtl/sequencer.sv
// Fetch/decode/execute control sequencer: state register plus a combinational decode of state, op and z_flag into control strobes.
// Defining SEQUENCER_HALT_EN adds the HALT state and the halted port (op 111 halts); otherwise op 111 is a 4-cycle NOP.
module sequencer #(
    parameter int WORD_W = 10,
    parameter int OP_W   = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            ALU_xnor,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            load_MAR,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            CS,
    output logic            R_NW
`ifdef SEQUENCER_HALT_EN
    ,
    output logic            halted
`endif
);

    if ((OP_W < 3) || (OP_W > WORD_W)) begin : g_width_check
        $error("sequencer: OP_W must be at least 3 and no wider than WORD_W");
    end

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XNOR  = OP_W'(6);
`ifdef SEQUENCER_HALT_EN
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);
`endif

    typedef enum logic [3:0] {
        FETCH0,
        FETCH1,
        FETCH2,
        DECODE,
        ST0,
        ST1,
        RD0,
        RD1
`ifdef SEQUENCER_HALT_EN
        ,
        HALT
`endif
    } state_e;

    typedef struct packed {
        logic acc_bus;
        logic load_acc;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic alu_xor;
        logic alu_xnor;
        logic pc_bus;
        logic load_pc;
        logic inc_pc;
        logic mdr_bus;
        logic load_mdr;
        logic load_mar;
        logic load_ir;
        logic addr_bus;
        logic cs;
        logic r_nw;
`ifdef SEQUENCER_HALT_EN
        logic halted;
`endif
    } ctrl_t;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            FETCH0: begin
                ctrl.pc_bus   = 1'b1;
                ctrl.load_mar = 1'b1;
                ctrl.load_pc  = 1'b1;
                ctrl.inc_pc   = 1'b1;
                state_d       = FETCH1;
            end
            FETCH1: begin
                ctrl.cs       = 1'b1;
                ctrl.r_nw     = 1'b1;
                ctrl.load_mdr = 1'b1;
                state_d       = FETCH2;
            end
            FETCH2: begin
                ctrl.mdr_bus = 1'b1;
                ctrl.load_ir = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                // The address field goes to MAR for operands, or to PC for a taken branch.
                ctrl.addr_bus = 1'b1;
                case (op)
                    OP_STORE: begin
                        ctrl.load_mar = 1'b1;
                        state_d       = ST0;
                    end
                    OP_LOAD, OP_ADD, OP_SUB, OP_XOR, OP_XNOR: begin
                        ctrl.load_mar = 1'b1;
                        state_d       = RD0;
                    end
                    OP_BNE: begin
                        ctrl.load_pc  = !z_flag;
                        ctrl.load_mar = z_flag;
                        state_d       = FETCH0;
                    end
`ifdef SEQUENCER_HALT_EN
                    OP_HALT: begin
                        ctrl        = '0;
                        ctrl.halted = 1'b1;
                        state_d     = HALT;
                    end
`endif
                    default: begin
                        ctrl.load_mar = 1'b1;
                        state_d       = FETCH0;
                    end
                endcase
            end
            ST0: begin
                ctrl.acc_bus  = 1'b1;
                ctrl.load_mdr = 1'b1;
                state_d       = ST1;
            end
            ST1: begin
                ctrl.cs = 1'b1;
                state_d = FETCH0;
            end
            RD0: begin
                ctrl.cs       = 1'b1;
                ctrl.r_nw     = 1'b1;
                ctrl.load_mdr = 1'b1;
                state_d       = RD1;
            end
            RD1: begin
                ctrl.mdr_bus  = 1'b1;
                ctrl.load_acc = 1'b1;
                case (op)
                    OP_ADD: begin
                        ctrl.alu_acc = 1'b1;
                        ctrl.alu_add = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl.alu_acc = 1'b1;
                        ctrl.alu_sub = 1'b1;
                    end
                    OP_XOR: begin
                        ctrl.alu_acc = 1'b1;
                        ctrl.alu_xor = 1'b1;
                    end
                    OP_XNOR: begin
                        ctrl.alu_acc  = 1'b1;
                        ctrl.alu_xnor = 1'b1;
                    end
                    default: ctrl.alu_acc = 1'b0;
                endcase
                state_d = FETCH0;
            end
`ifdef SEQUENCER_HALT_EN
            HALT: begin
                ctrl.halted = 1'b1;
                state_d     = HALT;
            end
`endif
            default: begin
                ctrl    = '0;
                state_d = FETCH0;
            end
        endcase
        // Reset blanks every strobe in the same cycle, so a pending store never reaches memory.
        if (!n_reset) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q <= FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    assign ACC_bus  = ctrl.acc_bus;
    assign load_ACC = ctrl.load_acc;
    assign ALU_ACC  = ctrl.alu_acc;
    assign ALU_add  = ctrl.alu_add;
    assign ALU_sub  = ctrl.alu_sub;
    assign ALU_xor  = ctrl.alu_xor;
    assign ALU_xnor = ctrl.alu_xnor;
    assign PC_bus   = ctrl.pc_bus;
    assign load_PC  = ctrl.load_pc;
    assign INC_PC   = ctrl.inc_pc;
    assign MDR_bus  = ctrl.mdr_bus;
    assign load_MDR = ctrl.load_mdr;
    assign load_MAR = ctrl.load_mar;
    assign load_IR  = ctrl.load_ir;
    assign Addr_bus = ctrl.addr_bus;
    assign CS       = ctrl.cs;
    assign R_NW     = ctrl.r_nw;
`ifdef SEQUENCER_HALT_EN
    assign halted   = ctrl.halted;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: per-cycle control-strobe vectors for every instruction class, reset abort and op 111.
// Builds with or without SEQUENCER_HALT_EN; the op 111 section expects the matching behaviour.
module tb_sequencer;

    logic       clock;
    logic       n_reset;
    logic [2:0] op;
    logic       z_flag;
    logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor;
    logic PC_bus, load_PC, INC_PC, MDR_bus, load_MDR, load_MAR, load_IR, Addr_bus, CS, R_NW;
`ifdef SEQUENCER_HALT_EN
    logic halted;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [16:0] C_ACC_BUS  = 17'h10000;
    localparam logic [16:0] C_LOAD_ACC = 17'h08000;
    localparam logic [16:0] C_ALU_ACC  = 17'h04000;
    localparam logic [16:0] C_ADD      = 17'h02000;
    localparam logic [16:0] C_SUB      = 17'h01000;
    localparam logic [16:0] C_XOR      = 17'h00800;
    localparam logic [16:0] C_XNOR     = 17'h00400;
    localparam logic [16:0] C_PC_BUS   = 17'h00200;
    localparam logic [16:0] C_LOAD_PC  = 17'h00100;
    localparam logic [16:0] C_INC_PC   = 17'h00080;
    localparam logic [16:0] C_MDR_BUS  = 17'h00040;
    localparam logic [16:0] C_LOAD_MDR = 17'h00020;
    localparam logic [16:0] C_LOAD_MAR = 17'h00010;
    localparam logic [16:0] C_LOAD_IR  = 17'h00008;
    localparam logic [16:0] C_ADDR_BUS = 17'h00004;
    localparam logic [16:0] C_CS       = 17'h00002;
    localparam logic [16:0] C_R_NW     = 17'h00001;

    localparam logic [16:0] E_F0      = C_PC_BUS | C_LOAD_MAR | C_LOAD_PC | C_INC_PC;
    localparam logic [16:0] E_F1      = C_CS | C_R_NW | C_LOAD_MDR;
    localparam logic [16:0] E_F2      = C_MDR_BUS | C_LOAD_IR;
    localparam logic [16:0] E_DEC_MAR = C_ADDR_BUS | C_LOAD_MAR;
    localparam logic [16:0] E_DEC_PC  = C_ADDR_BUS | C_LOAD_PC;
    localparam logic [16:0] E_RD0     = C_CS | C_R_NW | C_LOAD_MDR;
    localparam logic [16:0] E_RD1     = C_MDR_BUS | C_LOAD_ACC;
    localparam logic [16:0] E_ST0     = C_ACC_BUS | C_LOAD_MDR;
    localparam logic [16:0] E_ST1     = C_CS;

    logic [16:0] ctrl_vec;
    assign ctrl_vec = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor,
                       PC_bus, load_PC, INC_PC, MDR_bus, load_MDR, load_MAR, load_IR,
                       Addr_bus, CS, R_NW};

    sequencer #(.WORD_W(10), .OP_W(3)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .op       (op),
        .z_flag   (z_flag),
        .ACC_bus  (ACC_bus),
        .load_ACC (load_ACC),
        .ALU_ACC  (ALU_ACC),
        .ALU_add  (ALU_add),
        .ALU_sub  (ALU_sub),
        .ALU_xor  (ALU_xor),
        .ALU_xnor (ALU_xnor),
        .PC_bus   (PC_bus),
        .load_PC  (load_PC),
        .INC_PC   (INC_PC),
        .MDR_bus  (MDR_bus),
        .load_MDR (load_MDR),
        .load_MAR (load_MAR),
        .load_IR  (load_IR),
        .Addr_bus (Addr_bus),
        .CS       (CS),
        .R_NW     (R_NW)
`ifdef SEQUENCER_HALT_EN
        ,
        .halted   (halted)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current cycle's strobes, then move to 1 time unit after the next rising edge.
    task automatic expect_cycle(input string tag, input logic [16:0] exp);
        check(tag, {15'd0, ctrl_vec}, {15'd0, exp});
`ifdef SEQUENCER_HALT_EN
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [2:0] opc, input logic [16:0] rd1_exp);
        op = opc;
        expect_cycle({tag, "_f0"}, E_F0);
        expect_cycle({tag, "_f1"}, E_F1);
        expect_cycle({tag, "_f2"}, E_F2);
        expect_cycle({tag, "_dec"}, E_DEC_MAR);
        expect_cycle({tag, "_rd0"}, E_RD0);
        expect_cycle({tag, "_rd1"}, rd1_exp);
    endtask

    initial begin
        n_reset = 1'b0;
        op      = 3'b000;
        z_flag  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ctrl", {15'd0, ctrl_vec}, 32'd0);
`ifdef SEQUENCER_HALT_EN
        check("rst_halted", {31'd0, halted}, 32'd0);
`endif
        n_reset = 1'b1;
        #1;

        // LOAD: 6 cycles, no ALU involvement; the following FETCH0 is cycle 7
        run_alu("load", 3'b000, E_RD1);
        run_alu("add",  3'b010, E_RD1 | C_ALU_ACC | C_ADD);
        run_alu("sub",  3'b011, E_RD1 | C_ALU_ACC | C_SUB);
        run_alu("xor",  3'b101, E_RD1 | C_ALU_ACC | C_XOR);
        run_alu("xnor", 3'b110, E_RD1 | C_ALU_ACC | C_XNOR);

        op = 3'b001;
        expect_cycle("st_f0", E_F0);
        expect_cycle("st_f1", E_F1);
        expect_cycle("st_f2", E_F2);
        expect_cycle("st_dec", E_DEC_MAR);
        expect_cycle("st_st0", E_ST0);
        expect_cycle("st_st1", E_ST1);

        // BNE taken: z_flag toggled outside DECODE must not matter
        op = 3'b100;
        z_flag = 1'b1;
        expect_cycle("bne0_f0", E_F0);
        expect_cycle("bne0_f1", E_F1);
        expect_cycle("bne0_f2", E_F2);
        z_flag = 1'b0;
        #1;
        expect_cycle("bne0_dec", E_DEC_PC);
        z_flag = 1'b0;
        expect_cycle("bne1_f0", E_F0);
        expect_cycle("bne1_f1", E_F1);
        expect_cycle("bne1_f2", E_F2);
        z_flag = 1'b1;
        #1;
        expect_cycle("bne1_dec", E_DEC_MAR);
        z_flag = 1'b0;

        op = 3'b111;
        expect_cycle("op7_f0", E_F0);
        expect_cycle("op7_f1", E_F1);
        expect_cycle("op7_f2", E_F2);
`ifdef SEQUENCER_HALT_EN
        for (int i = 0; i < 22; i++) begin
            check("halt_ctrl", {15'd0, ctrl_vec}, 32'd0);
            check("halt_flag", {31'd0, halted}, 32'd1);
            z_flag = ~z_flag;
            @(posedge clock);
            #1;
        end
        z_flag  = 1'b0;
        n_reset = 1'b0;
        #1;
        check("halt_rst_ctrl", {15'd0, ctrl_vec}, 32'd0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        #1;
`else
        expect_cycle("nop_dec", E_DEC_MAR);
`endif
        // Fresh instruction at FETCH0: cycle 5 after NOP, or first cycle after halt reset
        op = 3'b001;
        expect_cycle("sr_f0", E_F0);
        expect_cycle("sr_f1", E_F1);
        expect_cycle("sr_f2", E_F2);
        expect_cycle("sr_dec", E_DEC_MAR);
        check("sr_st0_pre", {15'd0, ctrl_vec}, {15'd0, E_ST0});
        n_reset = 1'b0;
        #1;
        check("sr_st0_rst", {15'd0, ctrl_vec}, 32'd0);
        @(posedge clock);
        #1;
        check("sr_after_edge", {15'd0, ctrl_vec}, 32'd0);
        n_reset = 1'b1;
        #1;
        expect_cycle("sr_rel_f0", E_F0);
        expect_cycle("sr_rel_f1", E_F1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
